// File: rtl/imem_loader.sv
// Boot-time loader: parses framed byte stream into 20-bit words and writes the instruction
// memory, holding the core in reset until a frame with a good checksum completes.
module imem_loader #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 20,
   parameter logic [7:0]  SYNC   = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   input  logic [7:0]        in_byte,
   output logic              in_rdy,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_written
);

   localparam int unsigned HiBits = ADDR_W - 8;
   localparam logic [15:0] MaxCnt = 16'(1 << ADDR_W);

   typedef enum logic [2:0] {StIdle, StHdr, StData, StCsum, StDone, StErr} state_t;

   state_t              state_q, state_d;
   logic [1:0]          hdr_idx_q, hdr_idx_d;
   logic [1:0]          byte_idx_q, byte_idx_d;
   logic [7:0]          b0_q, b0_d, b1_q, b1_d;
   logic [7:0]          csum_q, csum_d;
   logic [7:0]          cnt_lo_q, cnt_lo_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [ADDR_W:0]     ww_q, ww_d, ww_inc;
   logic [15:0]         cnt_full;
   logic                xfer;

   logic                in_rdy_q, in_rdy_d;
   logic                im_we_q, im_we_d;
   logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
   logic [DATA_W-1:0]   im_wdata_q, im_wdata_d;
   logic                cpu_hold_q, cpu_hold_d;
   logic                load_done_q, load_done_d;
   logic                load_err_q, load_err_d;

   always_comb begin
      state_d     = state_q;
      hdr_idx_d   = hdr_idx_q;
      byte_idx_d  = byte_idx_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      csum_d      = csum_q;
      cnt_lo_d    = cnt_lo_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      ww_d        = ww_q;
      in_rdy_d    = 1'b1;
      im_we_d     = 1'b0;
      im_addr_d   = im_addr_q;
      im_wdata_d  = im_wdata_q;
      cpu_hold_d  = cpu_hold_q;
      load_done_d = load_done_q;
      load_err_d  = load_err_q;
      xfer        = in_vld & in_rdy_q;
      ww_inc      = ww_q + 1'b1;
      cnt_full    = {in_byte, cnt_lo_q};

      unique case (state_q)
         StHdr: begin
            if (xfer) begin
               csum_d    = csum_q + in_byte;
               hdr_idx_d = hdr_idx_q + 2'd1;
               unique case (hdr_idx_q)
                  2'd0: addr_d[7:0] = in_byte;
                  2'd1: begin
                     addr_d[ADDR_W-1:8] = in_byte[HiBits-1:0];
                     if (in_byte[7:HiBits] != '0) begin
                        state_d    = StErr;
                        load_err_d = 1'b1;
                     end
                  end
                  2'd2: cnt_lo_d = in_byte;
                  default: begin
                     if (cnt_full == 16'd0 || cnt_full > MaxCnt) begin
                        state_d    = StErr;
                        load_err_d = 1'b1;
                     end else begin
                        cnt_d      = cnt_full[ADDR_W:0];
                        byte_idx_d = 2'd0;
                        state_d    = StData;
                     end
                  end
               endcase
            end
         end
         StData: begin
            if (xfer) begin
               csum_d = csum_q + in_byte;
               unique case (byte_idx_q)
                  2'd0: begin
                     b0_d       = in_byte;
                     byte_idx_d = 2'd1;
                  end
                  2'd1: begin
                     b1_d       = in_byte;
                     byte_idx_d = 2'd2;
                  end
                  default: begin
                     // Write goes out next cycle; in_rdy drops for that cycle only.
                     byte_idx_d = 2'd0;
                     im_we_d    = 1'b1;
                     in_rdy_d   = 1'b0;
                     im_addr_d  = addr_q;
                     im_wdata_d = {in_byte[3:0], b1_q, b0_q};
                     addr_d     = addr_q + 1'b1;
                     ww_d       = ww_inc;
                     if (ww_inc == cnt_q) state_d = StCsum;
                  end
               endcase
            end
         end
         StCsum: begin
            if (xfer) begin
               if (in_byte == csum_q) begin
                  state_d     = StDone;
                  load_done_d = 1'b1;
                  cpu_hold_d  = 1'b0;
               end else begin
                  state_d    = StErr;
                  load_err_d = 1'b1;
               end
            end
         end
         default: begin
            // Idle, Done and Err all hunt for SYNC and drop everything else.
            if (xfer && in_byte == SYNC) begin
               state_d     = StHdr;
               hdr_idx_d   = 2'd0;
               byte_idx_d  = 2'd0;
               csum_d      = 8'd0;
               ww_d        = '0;
               load_done_d = 1'b0;
               load_err_d  = 1'b0;
               cpu_hold_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         hdr_idx_q   <= 2'd0;
         byte_idx_q  <= 2'd0;
         b0_q        <= 8'd0;
         b1_q        <= 8'd0;
         csum_q      <= 8'd0;
         cnt_lo_q    <= 8'd0;
         addr_q      <= '0;
         cnt_q       <= '0;
         ww_q        <= '0;
         in_rdy_q    <= 1'b1;
         im_we_q     <= 1'b0;
         im_addr_q   <= '0;
         im_wdata_q  <= '0;
         cpu_hold_q  <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_idx_q   <= hdr_idx_d;
         byte_idx_q  <= byte_idx_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         csum_q      <= csum_d;
         cnt_lo_q    <= cnt_lo_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         ww_q        <= ww_d;
         in_rdy_q    <= in_rdy_d;
         im_we_q     <= im_we_d;
         im_addr_q   <= im_addr_d;
         im_wdata_q  <= im_wdata_d;
         cpu_hold_q  <= cpu_hold_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
      end
   end

   assign in_rdy        = in_rdy_q;
   assign im_we         = im_we_q;
   assign im_addr       = im_addr_q;
   assign im_wdata      = im_wdata_q;
   assign cpu_hold      = cpu_hold_q;
   assign load_done     = load_done_q;
   assign load_err      = load_err_q;
   assign words_written = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, wrap, header errors, noise, mid-frame reset.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_vld = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        in_rdy;
   logic        im_we;
   logic [12:0] im_addr;
   logic [19:0] im_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;
   logic [13:0] words_written;

   int vectors = 0;
   int miscompares = 0;
   int wr_count = 0;
   int rdy_low = 0;

   imem_loader dut (
      .clk           (clk),
      .rst           (rst),
      .in_vld        (in_vld),
      .in_byte       (in_byte),
      .in_rdy        (in_rdy),
      .im_we         (im_we),
      .im_addr       (im_addr),
      .im_wdata      (im_wdata),
      .cpu_hold      (cpu_hold),
      .load_done     (load_done),
      .load_err      (load_err),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (im_we === 1'b1) wr_count++;
      if (in_rdy === 1'b0) rdy_low++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      in_vld  = 1'b1;
      in_byte = b;
      while (in_rdy !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (n == 8) chk("rdy_wait", {31'd0, in_rdy}, 32'd1);
      @(posedge clk);
      #1 in_vld = 1'b0;
   endtask

   task automatic hdr(input logic [7:0] alo, input logic [7:0] ahi,
                      input logic [7:0] clo, input logic [7:0] chi);
      send(8'hA5);
      send(alo);
      send(ahi);
      send(clo);
      send(chi);
   endtask

   task automatic word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send(b0);
      send(b1);
      send(b2);
   endtask

   task automatic clr_counts();
      wr_count = 0;
      rdy_low  = 0;
   endtask

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
      chk("rst_im_we", {31'd0, im_we}, 32'd0);
      chk("rst_im_addr", {19'd0, im_addr}, 32'd0);
      chk("rst_im_wdata", {12'd0, im_wdata}, 32'd0);
      chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
      chk("rst_done", {31'd0, load_done}, 32'd0);
      chk("rst_err", {31'd0, load_err}, 32'd0);
      chk("rst_ww", {18'd0, words_written}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Noise then good 2-word frame
      clr_counts();
      send(8'h00); send(8'hFF); send(8'h12);
      chk("noise_hold", {31'd0, cpu_hold}, 32'd0);
      hdr(8'h10, 8'h00, 8'h02, 8'h00);
      chk("g_hold", {31'd0, cpu_hold}, 32'd1);
      word(8'h45, 8'h23, 8'h01);
      chk("g_we0", {31'd0, im_we}, 32'd1);
      chk("g_rdy0", {31'd0, in_rdy}, 32'd0);
      chk("g_addr0", {19'd0, im_addr}, 32'h010);
      chk("g_data0", {12'd0, im_wdata}, 32'h12345);
      word(8'hDE, 8'hBC, 8'h0A);
      chk("g_we1", {31'd0, im_we}, 32'd1);
      chk("g_addr1", {19'd0, im_addr}, 32'h011);
      chk("g_data1", {12'd0, im_wdata}, 32'hABCDE);
      send(8'h1F);
      chk("g_done", {31'd0, load_done}, 32'd1);
      chk("g_err", {31'd0, load_err}, 32'd0);
      chk("g_hold_rel", {31'd0, cpu_hold}, 32'd0);
      chk("g_ww", {18'd0, words_written}, 32'd2);
      chk("g_wrcnt", wr_count, 32'd2);
      chk("g_rdylow", rdy_low, 32'd2);

      // Second good frame: SYNC clears done, csum sets it again
      clr_counts();
      send(8'hA5);
      chk("f2_done_clr", {31'd0, load_done}, 32'd0);
      chk("f2_hold", {31'd0, cpu_hold}, 32'd1);
      chk("f2_ww_clr", {18'd0, words_written}, 32'd0);
      send(8'h00); send(8'h01); send(8'h01); send(8'h00);
      word(8'h11, 8'h22, 8'hF3);
      chk("f2_addr", {19'd0, im_addr}, 32'h100);
      chk("f2_data", {12'd0, im_wdata}, 32'h32211);
      send(8'h28);
      chk("f2_done", {31'd0, load_done}, 32'd1);
      chk("f2_hold_rel", {31'd0, cpu_hold}, 32'd0);

      // Bad checksum
      clr_counts();
      hdr(8'h10, 8'h00, 8'h02, 8'h00);
      word(8'h45, 8'h23, 8'h01);
      word(8'hDE, 8'hBC, 8'h0A);
      send(8'h20);
      chk("bc_err", {31'd0, load_err}, 32'd1);
      chk("bc_done", {31'd0, load_done}, 32'd0);
      chk("bc_hold", {31'd0, cpu_hold}, 32'd1);
      chk("bc_wrcnt", wr_count, 32'd2);

      // Address wrap 0x1FFF -> 0x0000
      clr_counts();
      hdr(8'hFF, 8'h1F, 8'h02, 8'h00);
      chk("wr_err_clr", {31'd0, load_err}, 32'd0);
      word(8'h01, 8'h00, 8'h00);
      chk("wr_addr0", {19'd0, im_addr}, 32'h1FFF);
      chk("wr_data0", {12'd0, im_wdata}, 32'h00001);
      word(8'h02, 8'h00, 8'h00);
      chk("wr_addr1", {19'd0, im_addr}, 32'h0000);
      chk("wr_data1", {12'd0, im_wdata}, 32'h00002);
      send(8'h23);
      chk("wr_done", {31'd0, load_done}, 32'd1);

      // Header errors
      clr_counts();
      send(8'hA5); send(8'h10); send(8'h20);
      chk("ha_err", {31'd0, load_err}, 32'd1);
      chk("ha_hold", {31'd0, cpu_hold}, 32'd1);
      hdr(8'h10, 8'h00, 8'h00, 8'h00);
      chk("c0_err", {31'd0, load_err}, 32'd1);
      hdr(8'h10, 8'h00, 8'h01, 8'h20);
      chk("cbig_err", {31'd0, load_err}, 32'd1);
      chk("cbig_done", {31'd0, load_done}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("herr_wrcnt", wr_count, 32'd0);

      // Reset mid-frame after first of three words
      clr_counts();
      hdr(8'h00, 8'h00, 8'h03, 8'h00);
      word(8'h45, 8'h23, 8'h01);
      chk("mr_we", {31'd0, im_we}, 32'd1);
      chk("mr_data", {12'd0, im_wdata}, 32'h12345);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mr_rdy", {31'd0, in_rdy}, 32'd1);
      chk("mr_we0", {31'd0, im_we}, 32'd0);
      chk("mr_addr", {19'd0, im_addr}, 32'd0);
      chk("mr_wdata", {12'd0, im_wdata}, 32'd0);
      chk("mr_hold", {31'd0, cpu_hold}, 32'd0);
      chk("mr_err", {31'd0, load_err}, 32'd0);
      chk("mr_ww", {18'd0, words_written}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("mr_wrcnt", wr_count, 32'd1);

      clr_counts();
      hdr(8'h10, 8'h00, 8'h02, 8'h00);
      word(8'h45, 8'h23, 8'h01);
      word(8'hDE, 8'hBC, 8'h0A);
      chk("pr_addr1", {19'd0, im_addr}, 32'h011);
      send(8'h1F);
      chk("pr_done", {31'd0, load_done}, 32'd1);
      chk("pr_hold", {31'd0, cpu_hold}, 32'd0);
      chk("pr_ww", {18'd0, words_written}, 32'd2);
      chk("pr_wrcnt", wr_count, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
